hermes_periph_port: RTL and testbench

//  Peripheral endpoint at a Hermes mesh edge. Wires to one boundary port of an edge PE
//  (that PE's noc_tx_o/noc_credit_i/noc_data_o and noc_rx_i/noc_credit_o/noc_data_i).

---
 rtl/hermes_periph_pkg.sv | 28 ++
 rtl/hermes_periph_fifo.sv | 55 +++++
 rtl/hermes_periph_port.sv | 172 +++++++++++++++++
 tb/tb_hermes_periph_port.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hermes_periph_pkg.sv
// Shared types for the Hermes peripheral endpoint: packet-walk states,
// the tagged flit record and the end-of-packet decode used by both directions.
package hermes_periph_pkg;

  localparam int HERMES_FLIT_W = 32;

  // Position inside a Hermes packet: header, size word, payload.
  typedef enum logic [1:0] {
    HDR  = 2'd0,
    SIZE = 2'd1,
    PAY  = 2'd2
  } periph_state_t;

  // Flit as stored on the host side: start/end-of-packet tags plus data.
  typedef struct packed {
    logic                     sop;
    logic                     eop;
    logic [HERMES_FLIT_W-1:0] data;
  } periph_flit_t;

  // A flit closes its packet when it is a zero size word, or the final payload.
  function automatic logic last_flit(input periph_state_t st,
                                     input logic          size_is_zero,
                                     input logic          cnt_is_one);
    return ((st == SIZE) && size_is_zero) || ((st == PAY) && cnt_is_one);
  endfunction

endpackage

// File: rtl/hermes_periph_fifo.sv
// Synchronous FIFO with a registered occupancy count. The head entry is read
// combinationally so a word written at one edge is visible the following cycle.
module hermes_periph_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr_q];

  // Storage is plain data and carries no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy; reset flushes the contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hermes_periph_port.sv
// Peripheral endpoint on a Hermes mesh edge port. Received packets are tagged
// with sop/eop and queued for the host; host flits are queued and injected,
// with the start of each outgoing packet gated by the PE release signal.
module hermes_periph_port
  import hermes_periph_pkg::*;
#(
  parameter int FLIT_SIZE      = 32,
  parameter int RX_BUFFER_SIZE = 8,
  parameter int TX_BUFFER_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 release_i,
  input  logic                 noc_rx_i,
  output logic                 noc_credit_o,
  input  logic [FLIT_SIZE-1:0] noc_data_i,
  output logic                 noc_tx_o,
  input  logic                 noc_credit_i,
  output logic [FLIT_SIZE-1:0] noc_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic [FLIT_SIZE-1:0] rx_data_o,
  output logic                 rx_sop_o,
  output logic                 rx_eop_o,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic [FLIT_SIZE-1:0] tx_data_i,
  output logic [15:0]          rx_pkt_cnt_o,
  output logic [15:0]          tx_pkt_cnt_o
);

  // Host-side rx record, sized by FLIT_SIZE.
  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [FLIT_SIZE-1:0] data;
  } rx_word_t;

  logic                 live_q;

  logic                 rx_full;
  logic                 rx_empty;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_last;
  rx_word_t             rx_wr;
  rx_word_t             rx_rd;
  periph_state_t        rx_state_q;
  logic [FLIT_SIZE-1:0] rx_cnt_q;

  logic                 tx_full;
  logic                 tx_empty;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_last;
  periph_state_t        tx_state_q;
  logic [FLIT_SIZE-1:0] tx_cnt_q;

  // Holds credit/ready low for the first cycle out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) live_q <= 1'b0;
    else         live_q <= 1'b1;
  end

  // ---------------- receive path: mesh -> host ----------------
  assign noc_credit_o = live_q & ~rx_full;
  assign rx_push      = noc_rx_i & noc_credit_o;
  assign rx_last      = last_flit(rx_state_q, noc_data_i == '0,
                                  rx_cnt_q == FLIT_SIZE'(1));
  assign rx_wr.sop    = (rx_state_q == HDR);
  assign rx_wr.eop    = rx_last;
  assign rx_wr.data   = noc_data_i;
  assign rx_pop       = rx_valid_o & rx_ready_i;

  hermes_periph_fifo #(
    .WIDTH (FLIT_SIZE + 2),
    .DEPTH (RX_BUFFER_SIZE)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rx_push),
    .data_i  (rx_wr),
    .pop_i   (rx_pop),
    .data_o  (rx_rd),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  assign rx_valid_o = ~rx_empty;
  assign rx_data_o  = rx_rd.data;
  assign rx_sop_o   = rx_rd.sop;
  assign rx_eop_o   = rx_rd.eop;

  // Walk each accepted flit through header/size/payload and count closed packets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_q   <= HDR;
      rx_cnt_q     <= '0;
      rx_pkt_cnt_o <= '0;
    end else if (rx_push) begin
      case (rx_state_q)
        HDR:  rx_state_q <= SIZE;
        SIZE: begin
          if (noc_data_i == '0) begin
            rx_state_q <= HDR;
          end else begin
            rx_cnt_q   <= noc_data_i;
            rx_state_q <= PAY;
          end
        end
        PAY: begin
          rx_cnt_q <= rx_cnt_q - FLIT_SIZE'(1);
          if (rx_cnt_q == FLIT_SIZE'(1)) rx_state_q <= HDR;
        end
        default: rx_state_q <= HDR;
      endcase
      if (rx_last) rx_pkt_cnt_o <= rx_pkt_cnt_o + 16'd1;
    end
  end

  // ---------------- transmit path: host -> mesh ----------------
  assign tx_ready_o = live_q & ~tx_full;
  assign tx_push    = tx_valid_i & tx_ready_o;
  // Release only gates the header; once a packet is under way it runs to the end.
  // noc_credit_i is deliberately absent here so valid never waits on credit.
  assign noc_tx_o   = ~tx_empty & ((tx_state_q != HDR) | release_i);
  assign tx_pop     = noc_tx_o & noc_credit_i;
  assign tx_last    = last_flit(tx_state_q, noc_data_o == '0,
                                tx_cnt_q == FLIT_SIZE'(1));

  hermes_periph_fifo #(
    .WIDTH (FLIT_SIZE),
    .DEPTH (TX_BUFFER_SIZE)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_push),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop),
    .data_o  (noc_data_o),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  // Track the outgoing packet on every handoff and count completed packets.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_q   <= HDR;
      tx_cnt_q     <= '0;
      tx_pkt_cnt_o <= '0;
    end else if (tx_pop) begin
      case (tx_state_q)
        HDR:  tx_state_q <= SIZE;
        SIZE: begin
          if (noc_data_o == '0) begin
            tx_state_q <= HDR;
          end else begin
            tx_cnt_q   <= noc_data_o;
            tx_state_q <= PAY;
          end
        end
        PAY: begin
          tx_cnt_q <= tx_cnt_q - FLIT_SIZE'(1);
          if (tx_cnt_q == FLIT_SIZE'(1)) tx_state_q <= HDR;
        end
        default: tx_state_q <= HDR;
      endcase
      if (tx_last) tx_pkt_cnt_o <= tx_pkt_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_hermes_periph_port.sv
// Directed bench for hermes_periph_port: rx packet decode table, rx FIFO
// full/credit behaviour, release-gated tx, tx stall and reset mid-packet.
module tb_hermes_periph_port;

  localparam int FW = 32;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          release_i;
  logic          noc_rx_i;
  logic          noc_credit_o;
  logic [FW-1:0] noc_data_i;
  logic          noc_tx_o;
  logic          noc_credit_i;
  logic [FW-1:0] noc_data_o;
  logic          rx_valid_o;
  logic          rx_ready_i;
  logic [FW-1:0] rx_data_o;
  logic          rx_sop_o;
  logic          rx_eop_o;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic [FW-1:0] tx_data_i;
  logic [15:0]   rx_pkt_cnt_o;
  logic [15:0]   tx_pkt_cnt_o;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] tx_q[$];

  typedef struct {
    logic [FW-1:0] flit;
    logic          sop;
    logic          eop;
    logic [15:0]   cnt;
  } rx_vec_t;

  rx_vec_t       rx_vec[6];
  logic [FW-1:0] fill[8];
  rx_vec_t       drain[8];
  logic [FW-1:0] exp_tx[5];

  always #5 clk = ~clk;

  hermes_periph_port dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .release_i    (release_i),
    .noc_rx_i     (noc_rx_i),
    .noc_credit_o (noc_credit_o),
    .noc_data_i   (noc_data_i),
    .noc_tx_o     (noc_tx_o),
    .noc_credit_i (noc_credit_i),
    .noc_data_o   (noc_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .rx_sop_o     (rx_sop_o),
    .rx_eop_o     (rx_eop_o),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_data_i    (tx_data_i),
    .rx_pkt_cnt_o (rx_pkt_cnt_o),
    .tx_pkt_cnt_o (tx_pkt_cnt_o)
  );

  // Record each flit that will be handed to the mesh at the coming rising edge.
  always @(negedge clk) begin
    #2;
    if (rst_ni && noc_tx_o && noc_credit_i) tx_q.push_back(noc_data_o);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Offer table entries first..last with the host always ready; each flit is
  // checked on the host side one cycle after it is accepted.
  task automatic run_rx(input int first, input int last);
    for (int i = first; i <= last + 1; i++) begin
      @(negedge clk);
      if (i > first) begin
        chk($sformatf("rx_valid[%0d]", i-1), rx_valid_o, 1);
        chk($sformatf("rx_data[%0d]", i-1), rx_data_o, rx_vec[i-1].flit);
        chk($sformatf("rx_sop[%0d]", i-1), rx_sop_o, rx_vec[i-1].sop);
        chk($sformatf("rx_eop[%0d]", i-1), rx_eop_o, rx_vec[i-1].eop);
        chk($sformatf("rx_pkt_cnt[%0d]", i-1), rx_pkt_cnt_o, rx_vec[i-1].cnt);
        chk($sformatf("credit[%0d]", i-1), noc_credit_o, 1);
      end
      if (i <= last) begin
        noc_rx_i   = 1'b1;
        noc_data_i = rx_vec[i].flit;
      end else begin
        noc_rx_i = 1'b0;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the push.
  task automatic tx_push(input logic [FW-1:0] d);
    int n = 0;
    tx_valid_i = 1'b1;
    tx_data_i  = d;
    while (!tx_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("tx_push_timeout", 0, 1);
    @(negedge clk);
    tx_valid_i = 1'b0;
  endtask

  initial begin
    rx_vec[0] = '{32'h0000_0102, 1'b1, 1'b0, 16'd0};
    rx_vec[1] = '{32'h0000_0002, 1'b0, 1'b0, 16'd0};
    rx_vec[2] = '{32'h0000_000A, 1'b0, 1'b0, 16'd0};
    rx_vec[3] = '{32'h0000_000B, 1'b0, 1'b1, 16'd1};
    rx_vec[4] = '{32'h0000_0001, 1'b1, 1'b0, 16'd1};
    rx_vec[5] = '{32'h0000_0000, 1'b0, 1'b1, 16'd2};

    fill = '{32'h10, 32'h6, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5};
    drain[0] = '{32'h6,  1'b0, 1'b0, 16'd0};
    drain[1] = '{32'hA0, 1'b0, 1'b0, 16'd0};
    drain[2] = '{32'hA1, 1'b0, 1'b0, 16'd0};
    drain[3] = '{32'hA2, 1'b0, 1'b0, 16'd0};
    drain[4] = '{32'hA3, 1'b0, 1'b0, 16'd0};
    drain[5] = '{32'hA4, 1'b0, 1'b0, 16'd0};
    drain[6] = '{32'hA5, 1'b0, 1'b1, 16'd0};
    drain[7] = '{32'h20, 1'b1, 1'b0, 16'd0};

    rst_ni       = 1'b0;
    release_i    = 1'b0;
    noc_rx_i     = 1'b0;
    noc_data_i   = '0;
    noc_credit_i = 1'b1;
    rx_ready_i   = 1'b0;
    tx_valid_i   = 1'b0;
    tx_data_i    = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_credit", noc_credit_o, 0);
    chk("rst_tx_ready", tx_ready_o, 0);
    chk("rst_noc_tx", noc_tx_o, 0);
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_cnt", rx_pkt_cnt_o, 0);
    chk("rst_tx_cnt", tx_pkt_cnt_o, 0);
    rst_ni = 1'b1;
    #1;
    chk("credit_before_first_edge", noc_credit_o, 0);
    @(negedge clk);
    chk("credit_after_reset", noc_credit_o, 1);
    chk("tx_ready_after_reset", tx_ready_o, 1);

    // Rx decode: {0x0102,2,A,B} then size-0 packet {0x0001,0}
    rx_ready_i = 1'b1;
    run_rx(0, 3);
    run_rx(4, 5);
    @(negedge clk);
    chk("rx_empty_after_table", rx_valid_o, 0);

    // Rx FIFO full: eight flits with host stalled, ninth held off
    rx_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      noc_rx_i   = 1'b1;
      noc_data_i = fill[i];
      @(negedge clk);
    end
    chk("full_credit", noc_credit_o, 0);
    chk("full_rx_cnt", rx_pkt_cnt_o, 3);
    noc_data_i = 32'h20;
    @(negedge clk);
    chk("full_credit_held", noc_credit_o, 0);
    chk("full_head", rx_data_o, 32'h10);
    chk("full_head_sop", rx_sop_o, 1);
    rx_ready_i = 1'b1;
    @(negedge clk);
    chk("credit_after_pop", noc_credit_o, 1);
    chk("head_after_pop", rx_data_o, 32'h6);
    rx_ready_i = 1'b0;
    @(negedge clk);
    chk("credit_after_ninth", noc_credit_o, 0);
    noc_rx_i   = 1'b0;
    rx_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_data[%0d]", i), rx_data_o, drain[i].flit);
      chk($sformatf("drain_sop[%0d]", i), rx_sop_o, drain[i].sop);
      chk($sformatf("drain_eop[%0d]", i), rx_eop_o, drain[i].eop);
      @(negedge clk);
    end
    chk("drain_empty", rx_valid_o, 0);
    noc_rx_i   = 1'b1;
    noc_data_i = 32'h0;
    @(negedge clk);
    noc_rx_i = 1'b0;
    chk("tail_valid", rx_valid_o, 1);
    chk("tail_eop", rx_eop_o, 1);
    chk("tail_sop", rx_sop_o, 0);
    chk("tail_rx_cnt", rx_pkt_cnt_o, 4);
    @(negedge clk);

    // Tx gated by release
    release_i    = 1'b0;
    noc_credit_i = 1'b1;
    tx_q.delete();
    tx_push(32'h0203);
    tx_push(32'h1);
    tx_push(32'hC);
    repeat (3) @(negedge clk);
    chk("tx_gated", noc_tx_o, 0);
    chk("tx_gated_sent", tx_q.size(), 0);
    chk("tx_gated_head", noc_data_o, 32'h0203);
    release_i = 1'b1;
    #1;
    chk("tx_released", noc_tx_o, 1);
    repeat (6) @(negedge clk);
    chk("tx1_count", tx_q.size(), 3);
    exp_tx[0] = 32'h0203; exp_tx[1] = 32'h1; exp_tx[2] = 32'hC;
    for (int i = 0; i < 3; i++)
      chk($sformatf("tx1_flit[%0d]", i), (i < tx_q.size()) ? tx_q[i] : 32'hDEAD_BEEF, exp_tx[i]);
    chk("tx1_pkt_cnt", tx_pkt_cnt_o, 1);
    chk("tx1_idle", noc_tx_o, 0);

    // Tx stall: credit withdrawn and release dropped after the header
    tx_q.delete();
    tx_push(32'h0304);
    @(negedge clk);
    release_i    = 1'b0;
    noc_credit_i = 1'b0;
    tx_push(32'h3);
    tx_push(32'hD1);
    tx_push(32'hD2);
    tx_push(32'hD3);
    chk("stall_tx_full", tx_ready_o, 0);
    chk("stall_valid", noc_tx_o, 1);
    chk("stall_data", noc_data_o, 32'h3);
    chk("stall_sent", tx_q.size(), 1);
    @(negedge clk);
    chk("stall_data_held", noc_data_o, 32'h3);
    noc_credit_i = 1'b1;
    repeat (8) @(negedge clk);
    chk("tx2_count", tx_q.size(), 5);
    exp_tx = '{32'h0304, 32'h3, 32'hD1, 32'hD2, 32'hD3};
    for (int i = 0; i < 5; i++)
      chk($sformatf("tx2_flit[%0d]", i), (i < tx_q.size()) ? tx_q[i] : 32'hDEAD_BEEF, exp_tx[i]);
    chk("tx2_pkt_cnt", tx_pkt_cnt_o, 2);
    chk("tx2_idle", noc_tx_o, 0);

    // Reset in the middle of an rx packet
    rx_ready_i = 1'b0;
    exp_tx = '{32'h0405, 32'h4, 32'hE1, 32'hE2, 32'h0};
    for (int i = 0; i < 4; i++) begin
      noc_rx_i   = 1'b1;
      noc_data_i = exp_tx[i];
      @(negedge clk);
    end
    noc_rx_i = 1'b0;
    chk("pre_reset_valid", rx_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("midrst_rx_valid", rx_valid_o, 0);
    chk("midrst_credit", noc_credit_o, 0);
    chk("midrst_tx_ready", tx_ready_o, 0);
    chk("midrst_noc_tx", noc_tx_o, 0);
    chk("midrst_rx_cnt", rx_pkt_cnt_o, 0);
    chk("midrst_tx_cnt", tx_pkt_cnt_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b1;
    run_rx(0, 3);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
